// File: rtl/lc3b_types.sv
// Shared LC-3b types: instruction opcodes and ALU operations.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

endpackage

// File: rtl/control.sv
// LC-3b multicycle control unit: Moore FSM sequencing fetch, decode,
// ALU ops, branches and LDR/STR against a handshaking memory.
module control
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_opcode opcode,
    input  logic       instruction5,
    input  logic       instruction11,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_cc,
    output logic       load_ir,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_regfile,
    output logic       pcmux_sel,
    output logic       storemux_sel,
    output logic [1:0] alumux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output logic       regfilemux_sel,
    output lc3b_aluop  aluop,
    output logic       mem_read,
    output logic       mem_write
);

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_ADD, S_AND, S_NOT, BR, BR_TAKEN,
        CALC_ADDR, LDR1, LDR2, STR1, STR2
    } state_t;

    state_t state_q, state_d;

    // Bit 11 selects JSR/JSRR; kept on the port for the datapath contract.
    logic unused;
    assign unused = instruction11;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH1;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: if (mem_resp) state_d = FETCH3;
            FETCH3: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    op_add:         state_d = S_ADD;
                    op_and:         state_d = S_AND;
                    op_not:         state_d = S_NOT;
                    op_br:          state_d = BR;
                    op_ldr, op_str: state_d = CALC_ADDR;
                    default:        state_d = FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: state_d = FETCH1;
            BR:        state_d = branch_enable ? BR_TAKEN : FETCH1;
            BR_TAKEN:  state_d = FETCH1;
            CALC_ADDR: state_d = (opcode == op_ldr) ? LDR1 : STR1;
            LDR1:      if (mem_resp) state_d = LDR2;
            LDR2:      state_d = FETCH1;
            STR1:      state_d = STR2;
            STR2:      if (mem_resp) state_d = FETCH1;
            default:   state_d = FETCH1;
        endcase
    end

    always_comb begin
        load_pc        = 1'b0;
        load_cc        = 1'b0;
        load_ir        = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_regfile   = 1'b0;
        pcmux_sel      = 1'b0;
        storemux_sel   = 1'b0;
        alumux_sel     = 2'd0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        aluop          = alu_add;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        // Reset masks the state decode so fetch1 loads never fire in reset.
        if (rst_n) begin
            case (state_q)
                FETCH1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                end
                FETCH2, LDR1: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                end
                FETCH3: load_ir = 1'b1;
                S_ADD, S_AND: begin
                    aluop        = (state_q == S_AND) ? alu_and : alu_add;
                    alumux_sel   = instruction5 ? 2'd1 : 2'd0;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                S_NOT: begin
                    aluop        = alu_not;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                BR_TAKEN: begin
                    pcmux_sel = 1'b1;
                    load_pc   = 1'b1;
                end
                CALC_ADDR: begin
                    alumux_sel = 2'd2;
                    load_mar   = 1'b1;
                end
                LDR2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                end
                STR1: begin
                    storemux_sel = 1'b1;
                    aluop        = alu_pass;
                    load_mdr     = 1'b1;
                end
                STR2: mem_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
